// File: rtl/cnn_accelerator.sv
`default_nettype none
// ============================================================================
// Module   : cnn_accelerator
// Brief    : Streaming box-kernel convolution (3x3 / 5x5 / 7x7) over a
//            49-deep pixel window, followed by a registered threshold
//            compare that drives a level-type detection flag.
// Revision : 1.0 - initial release
// ============================================================================
module cnn_accelerator #(
    parameter logic [13:0] THRESH_3 = 14'd0,
    parameter logic [13:0] THRESH_5 = 14'd0,
    parameter logic [13:0] THRESH_7 = 14'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pixel_in,
    input  logic [1:0] kernel_size,
    output logic       detected
);

    localparam int WIN_DEPTH = 49;
    localparam int TAPS_3    = 9;
    localparam int TAPS_5    = 25;

    // Sample window; win[0] is the newest pixel.
    logic [7:0]  win [0:WIN_DEPTH-1];

    // The three kernel sizes are nested, so the sum is split into the
    // 3x3 core, the 5x5 ring and the 7x7 ring; larger kernels add rings.
    logic [13:0] sum_core;
    logic [13:0] sum_ring5;
    logic [13:0] sum_ring7;

    logic [13:0] sum_next;
    logic [13:0] thr_next;

    logic [13:0] sum_q;
    logic [13:0] thr_q;

    // Shift the newest pixel in every cycle; reset clears the whole window.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < WIN_DEPTH; i++) begin
                win[i] <= 8'd0;
            end
        end else begin
            win[0] <= pixel_in;
            for (int i = 1; i < WIN_DEPTH; i++) begin
                win[i] <= win[i-1];
            end
        end
    end

    // Partial sums of the nested tap regions (unit weights, zero-extended).
    always_comb begin
        sum_core  = 14'd0;
        sum_ring5 = 14'd0;
        sum_ring7 = 14'd0;
        for (int i = 0; i < TAPS_3; i++) begin
            sum_core = sum_core + {6'd0, win[i]};
        end
        for (int i = TAPS_3; i < TAPS_5; i++) begin
            sum_ring5 = sum_ring5 + {6'd0, win[i]};
        end
        for (int i = TAPS_5; i < WIN_DEPTH; i++) begin
            sum_ring7 = sum_ring7 + {6'd0, win[i]};
        end
    end

    // Select active tap count and matching threshold from the current size.
    // Code 11 is deliberately folded into the 3x3 case.
    always_comb begin
        sum_next = sum_core;
        thr_next = THRESH_3;
        case (kernel_size)
            2'b01: begin
                sum_next = sum_core + sum_ring5;
                thr_next = THRESH_5;
            end
            2'b10: begin
                sum_next = sum_core + sum_ring5 + sum_ring7;
                thr_next = THRESH_7;
            end
            default: begin
                sum_next = sum_core;
                thr_next = THRESH_3;
            end
        endcase
    end

    // Register sum and its threshold together, then compare one stage later.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_q    <= 14'd0;
            thr_q    <= 14'd0;
            detected <= 1'b0;
        end else begin
            sum_q    <= sum_next;
            thr_q    <= thr_next;
            detected <= (sum_q > thr_q);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cnn_accelerator.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_accelerator
// Brief    : Self-checking bench for cnn_accelerator: vector table, directed
//            corner sequences and randomized traffic against a pixel-history
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_accelerator;

    logic       clk;
    logic       reset;
    logic [7:0] pixel_in;
    logic [1:0] kernel_size;
    logic       det0;
    logic       det1;

    int n_tests = 0;
    int n_fail  = 0;

    // Default thresholds.
    cnn_accelerator dut0 (
        .clk         (clk),
        .reset       (reset),
        .pixel_in    (pixel_in),
        .kernel_size (kernel_size),
        .detected    (det0)
    );

    // Non-trivial thresholds for boundary checks.
    cnn_accelerator #(
        .THRESH_3 (14'd100),
        .THRESH_5 (14'd1000),
        .THRESH_7 (14'd12494)
    ) dut1 (
        .clk         (clk),
        .reset       (reset),
        .pixel_in    (pixel_in),
        .kernel_size (kernel_size),
        .detected    (det1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: history of captured pixels (newest first), a
    // one-edge sum stage and a one-edge compare stage.
    // ------------------------------------------------------------------
    int hist[$];
    int m_sum;
    int m_thr0, m_thr1;
    int m_det0, m_det1;

    function automatic int taps_of(input logic [1:0] ks);
        case (ks)
            2'b01:   return 25;
            2'b10:   return 49;
            default: return 9;
        endcase
    endfunction

    function automatic int thr1_of(input logic [1:0] ks);
        case (ks)
            2'b01:   return 1000;
            2'b10:   return 12494;
            default: return 100;
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic [7:0] pix, input logic [1:0] ks);
        int s;
        if (!rst) begin
            hist.delete();
            m_sum = 0; m_thr0 = 0; m_thr1 = 0; m_det0 = 0; m_det1 = 0;
        end else begin
            m_det0 = (m_sum > m_thr0) ? 1 : 0;
            m_det1 = (m_sum > m_thr1) ? 1 : 0;
            s = 0;
            for (int i = 0; i < taps_of(ks) && i < hist.size(); i++) s += hist[i];
            m_sum  = s;
            m_thr0 = 0;
            m_thr1 = thr1_of(ks);
            hist.push_front(int'(pix));
            if (hist.size() > 49) void'(hist.pop_back());
        end
    endtask

    // Apply inputs for one edge, advance model, sample 1 time unit later.
    task automatic tick(input logic rst, input logic [7:0] pix, input logic [1:0] ks);
        reset       = rst;
        pixel_in    = pix;
        kernel_size = ks;
        @(posedge clk);
        #1;
        model_edge(rst, pix, ks);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic       rst;
        logic [7:0] pix;
        logic [1:0] ks;
        logic       exp0;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic rst, input logic [7:0] pix, input logic [1:0] ks, input logic exp0);
        vec_t v;
        v.rst = rst; v.pix = pix; v.ks = ks; v.exp0 = exp0;
        vecs.push_back(v);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [1:0] ksv;
        logic [7:0] p;
        int         n;
        int         lim;

        reset = 1'b0; pixel_in = 8'hFF; kernel_size = 2'b00;

        // Reset held two edges with pixel 0xFF, then released with zeros.
        add_vec(1'b0, 8'hFF, 2'b00, 1'b0);
        add_vec(1'b0, 8'hFF, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) add_vec(1'b1, 8'h00, 2'b00, 1'b0);
        // Impulse residency for each kernel code; high after edges E+2..E+N+1.
        for (int k = 0; k < 4; k++) begin
            ksv = 2'(k);
            n   = taps_of(ksv);
            add_vec(1'b0, 8'h00, ksv, 1'b0);
            for (int i = 0; i <= n + 3; i++)
                add_vec(1'b1, (i == 0) ? 8'h01 : 8'h00, ksv,
                        (i >= 2 && i <= n + 1) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].rst, vecs[i].pix, vecs[i].ks);
            check($sformatf("vec%0d_det", i), int'(det0), int'(vecs[i].exp0));
        end

        // Threshold boundary, 3x3 with threshold 100: sum 99 stays low.
        tick(1'b0, 8'h00, 2'b00);
        for (int i = 0; i < 22; i++) begin
            tick(1'b1, (i < 9) ? 8'h0B : 8'h00, 2'b00);
            check("thr_sum99", int'(det1), 0);
        end
        // Sum 108 fires only on the edge where all nine are in the window.
        tick(1'b0, 8'h00, 2'b00);
        for (int i = 0; i < 14; i++) begin
            tick(1'b1, (i < 9) ? 8'h0C : 8'h00, 2'b00);
            check("thr_sum108", int'(det1), (i == 10) ? 1 : 0);
        end
        // Sum exactly equal to threshold never fires.
        tick(1'b0, 8'h00, 2'b00);
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, (i == 0) ? 8'h64 : 8'h00, 2'b00);
            check("thr_sum100", int'(det1), 0);
        end

        // Kernel switch mid-stream: 3x3 until the pixel leaves, then 7x7.
        tick(1'b0, 8'h00, 2'b00);
        for (int i = 0; i <= 52; i++) begin
            tick(1'b1, (i == 0) ? 8'h80 : 8'h00, (i >= 12) ? 2'b10 : 2'b00);
            if (i == 10) check("ksw_3x3_last", int'(det0), 1);
            if (i == 11) check("ksw_3x3_fall", int'(det0), 0);
            if (i >= 12) check("ksw_7x7", int'(det0), (i >= 13 && i <= 50) ? 1 : 0);
        end

        // Stream regression: random nonzero burst + hold in each mode.
        tick(1'b0, 8'h00, 2'b00);
        for (int k = 0; k < 3; k++) begin
            ksv = 2'(k);
            p   = 8'h01;
            for (int i = 0; i < 5; i++) begin
                p = 8'($urandom_range(1, 255));
                tick(1'b1, p, ksv);
            end
            for (int i = 0; i < 5; i++) tick(1'b1, p, ksv);
            check($sformatf("stream_mode%0d", k), int'(det0), 1);
            for (int i = 0; i < 2; i++) tick(1'b1, 8'h00, ksv);
        end

        // Full-scale 7x7 stream: 49 x 255 must not wrap.
        for (int i = 0; i < 52; i++) tick(1'b1, 8'hFF, 2'b10);
        check("max_sum", int'(dut0.sum_q), 12495);
        check("max_det0", int'(det0), 1);
        check("max_det1_thr12494", int'(det1), 1);

        // Mid-stream reset while detected is high.
        tick(1'b0, 8'hFF, 2'b10);
        check("midrst_det0", int'(det0), 0);
        check("midrst_det1", int'(det1), 0);
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 8'h00, 2'b10);
            check("post_rst_zero", int'(det0), 0);
        end

        // Randomized traffic against the reference model.
        ksv = 2'b00;
        lim = 255;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 16) == 0) begin
                case ($urandom_range(0, 3))
                    0: lim = 0;
                    1: lim = 12;
                    2: lim = 40;
                    default: lim = 255;
                endcase
            end
            if ($urandom_range(0, 7) == 0) ksv = 2'($urandom_range(0, 3));
            tick(($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1,
                 8'($urandom_range(0, lim)), ksv);
            check("rand_det0", int'(det0), m_det0);
            check("rand_det1", int'(det1), m_det1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
